ewrapper_txo_framer: RTL

//  Transmit-side link framer on the slow core clock. Accepts 104-bit emesh write packets into a small FIFO.

---
 rtl/ewrapper_txo_framer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ewrapper_txo_framer.sv
// Transmit link framer: buffers 104-bit emesh packets and emits each as two 72-bit
// beats (8 data lanes + frame lane) for the DDR serializer, gated by remote link wait.
module ewrapper_txo_framer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK_DIV_IN,
    input  logic         RESET,
    input  logic         EMESH_ACCESS_IN,
    input  logic [103:0] EMESH_PACKET_IN,
    output logic         EMESH_WAIT_OUT,
    input  logic         LINK_WAIT_IN,
    output logic [71:0]  DATA_OUT_FROM_DEVICE,
    output logic         OVERFLOW_OUT,
    output logic [15:0]  PKT_COUNT_OUT
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StB0, StB1} state_t;

    logic [103:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [71:0]   r_data;
    logic [71:0]   r_b1;
    logic [71:0]   w_data_nxt;
    logic [71:0]   w_b0;
    logic [71:0]   w_b1;
    logic [103:0]  w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_cnt_inc;
    logic          r_overflow;
    logic [15:0]   r_pkt_count;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = EMESH_ACCESS_IN & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // Lane 0 is the LSB byte; frame lane 7F then FF marks the packet start for the receiver.
    assign w_b0 = {8'h7F, w_head[63:40], w_head[95:64], w_head[103:96]};
    assign w_b1 = {8'hFF, 24'h0, w_head[31:0], w_head[39:32]};

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = '0;
        w_pop       = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty && !LINK_WAIT_IN) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StB0;
                    w_data_nxt  = w_b0;
                end
            end
            StB0: begin
                w_state_nxt = StB1;
                w_data_nxt  = r_b1;
            end
            StB1: begin
                w_cnt_inc = 1'b1;
                if (!w_empty && !LINK_WAIT_IN) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StB0;
                    w_data_nxt  = w_b0;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CLK_DIV_IN) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= EMESH_PACKET_IN;
        end
    end

    always_ff @(posedge CLK_DIV_IN) begin
        if (RESET) begin
            r_state     <= StIdle;
            r_data      <= '0;
            r_b1        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            if (w_pop) begin
                r_b1     <= w_b1;
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (EMESH_ACCESS_IN && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_cnt_inc) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign EMESH_WAIT_OUT       = w_full;
    assign DATA_OUT_FROM_DEVICE = r_data;
    assign OVERFLOW_OUT         = r_overflow;
    assign PKT_COUNT_OUT        = r_pkt_count;

endmodule
